// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//  Shares one instruction-memory port between the fetch stage (read-only) and
//  a debug/loader port (read/write). Round-robin arbitration, address range and
//  alignment checks, registered single-cycle responses, and halt/resume control
//  that blocks fetch grants while the debug port owns memory.
//
// Ports
//  clock, reset                 rising-edge clock, synchronous active-high reset
//  fetch_req/addr               fetch request and absolute word address
//  fetch_gnt                    comb: fetch request accepted this cycle
//  fetch_rvalid/rdata/err       registered fetch response (cycle after grant)
//  dbg_req/we/addr/wdata        debug request (we=1 write)
//  dbg_gnt                      comb: debug request accepted this cycle
//  dbg_rvalid/rdata/err         registered debug response/ack
//  dbg_halt, dbg_resume         halt / resume request pulses
//  halted                       1 while in the HALTED state
//  mem_address/data_in/read_write  drive to instruction memory
//  mem_data_out                 combinational read data from instruction memory
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter logic [31:0] MEM_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    output logic        fetch_err,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,

    input  logic        dbg_halt,
    input  logic        dbg_resume,
    output logic        halted,

    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW1 = AW + 1;

    // Offset of the last legal word; offsets are computed one bit wider so an
    // address below BASE_ADDR borrows into the top bit instead of wrapping.
    localparam logic [AW:0] LAST_OFF = {1'b0, MEM_BYTES} - AW1'(4);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DBG   = 1'b1
    } port_e;

    state_e state_q, state_d;
    port_e  rr_last_q, rr_last_d;

    logic          fetch_rvalid_q, fetch_rvalid_d;
    logic [DW-1:0] fetch_rdata_q,  fetch_rdata_d;
    logic          fetch_err_q,    fetch_err_d;
    logic          dbg_rvalid_q,   dbg_rvalid_d;
    logic [DW-1:0] dbg_rdata_q,    dbg_rdata_d;
    logic          dbg_err_q,      dbg_err_d;

    logic          fetch_elig;
    logic          dbg_elig;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic          sel_ok;

    // Word-aligned and inside [BASE_ADDR, BASE_ADDR + MEM_BYTES - 4].
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        logic [AW:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (addr[1:0] == 2'b00) && !off[AW] && (off <= LAST_OFF);
    endfunction

    // State and round-robin pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            rr_last_q <= PORT_DBG;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next state, arbitration, memory drive and response capture.
    always_comb begin
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        fetch_gnt      = 1'b0;
        dbg_gnt        = 1'b0;
        sel_addr       = dbg_addr;
        sel_we         = 1'b0;
        sel_ok         = 1'b0;
        mem_address    = BASE_ADDR;
        mem_data_in    = '0;
        mem_read_write = 1'b0;
        fetch_rvalid_d = 1'b0;
        fetch_rdata_d  = '0;
        fetch_err_d    = 1'b0;
        dbg_rvalid_d   = 1'b0;
        dbg_rdata_d    = '0;
        dbg_err_d      = 1'b0;

        // Halt has priority over a simultaneous resume.
        case (state_q)
            ST_RUN: begin
                if (dbg_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (dbg_resume && !dbg_halt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Grants use the current state; a collision goes to the port that did
        // not win last time.
        fetch_elig = fetch_req && (state_q == ST_RUN);
        dbg_elig   = dbg_req;
        if (fetch_elig && dbg_elig) begin
            fetch_gnt = (rr_last_q == PORT_DBG);
            dbg_gnt   = (rr_last_q == PORT_FETCH);
        end else begin
            fetch_gnt = fetch_elig;
            dbg_gnt   = dbg_elig;
        end

        if (fetch_gnt) begin
            rr_last_d = PORT_FETCH;
            sel_addr  = fetch_addr;
        end else if (dbg_gnt) begin
            rr_last_d = PORT_DBG;
            sel_addr  = dbg_addr;
            sel_we    = dbg_we;
        end

        // Writes are only allowed while the fetch stage is held off.
        sel_ok = (fetch_gnt || dbg_gnt) && addr_in_range(sel_addr)
                 && (!sel_we || (state_q == ST_HALTED));

        if (sel_ok) begin
            mem_address    = sel_addr;
            mem_read_write = sel_we;
            mem_data_in    = sel_we ? dbg_wdata : '0;
        end

        if (fetch_gnt) begin
            fetch_rvalid_d = 1'b1;
            fetch_err_d    = !sel_ok;
            fetch_rdata_d  = sel_ok ? mem_data_out : '0;
        end
        if (dbg_gnt) begin
            dbg_rvalid_d = 1'b1;
            dbg_err_d    = !sel_ok;
            dbg_rdata_d  = (sel_ok && !sel_we) ? mem_data_out : '0;
        end
    end

    // Response registers; reset drops any pending response.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= '0;
            fetch_err_q    <= 1'b0;
            dbg_rvalid_q   <= 1'b0;
            dbg_rdata_q    <= '0;
            dbg_err_q      <= 1'b0;
        end else begin
            fetch_rvalid_q <= fetch_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            fetch_err_q    <= fetch_err_d;
            dbg_rvalid_q   <= dbg_rvalid_d;
            dbg_rdata_q    <= dbg_rdata_d;
            dbg_err_q      <= dbg_err_d;
        end
    end

    assign fetch_rvalid = fetch_rvalid_q;
    assign fetch_rdata  = fetch_rdata_q;
    assign fetch_err    = fetch_err_q;
    assign dbg_rvalid   = dbg_rvalid_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign dbg_err      = dbg_err_q;
    assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_imem_port_arbiter.sv
`timescale 1ns/1ps
module tb_imem_port_arbiter;

    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam logic [31:0] MBYTES = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0] fetch_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        dbg_halt = 1'b0, dbg_resume = 1'b0;
    logic        halted;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imem_port_arbiter #(.BASE_ADDR(BASE), .MEM_BYTES(MBYTES)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .dbg_halt(dbg_halt), .dbg_resume(dbg_resume), .halted(halted),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Contents of any word never written: a simple function of its address.
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory behind the DUT: 64 real words at BASE, pattern elsewhere.
    logic [31:0] bmem [64];
    logic [31:0] boff;
    assign boff         = mem_address - BASE;
    assign mem_data_out = (boff < 32'd256) ? bmem[boff[7:2]] : pattern(mem_address);

    always @(posedge clock) begin
        if (mem_read_write && (boff < 32'd256)) bmem[boff[7:2]] <= mem_data_in;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_mem [logic [31:0]];
    bit          m_armed    = 1'b0;
    bit          m_halted   = 1'b0;
    bit          m_last_dbg = 1'b1;
    bit          e_frv = 1'b0, e_ferr = 1'b0, e_drv = 1'b0, e_derr = 1'b0;
    logic [31:0] e_frd = '0, e_drd = '0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return pattern(a);
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        longint unsigned la;
        la = 64'(a);
        return (la % 4 == 0) && (la >= 64'(BASE)) && (la + 4 <= 64'(BASE) + 64'(MBYTES));
    endfunction

    // Inputs are stable at the falling edge, so the model evaluates the cycle
    // here and predicts what the following rising edge must register.
    always @(negedge clock) begin
        bit          f_el, f_win, d_win, ok, wr;
        logic [31:0] a, xa, xd;
        f_el = 0; f_win = 0; d_win = 0; ok = 0; wr = 0; a = '0;
        xa = BASE; xd = '0;
        if (m_armed) begin
            chk("fetch_rvalid", 32'(fetch_rvalid), 32'(e_frv));
            chk("fetch_err",    32'(fetch_err),    32'(e_ferr));
            chk("fetch_rdata",  fetch_rdata,       e_frd);
            chk("dbg_rvalid",   32'(dbg_rvalid),   32'(e_drv));
            chk("dbg_err",      32'(dbg_err),      32'(e_derr));
            chk("dbg_rdata",    dbg_rdata,         e_drd);
        end
        if (reset) begin
            m_armed = 1; m_halted = 0; m_last_dbg = 1;
            e_frv = 0; e_ferr = 0; e_frd = '0; e_drv = 0; e_derr = 0; e_drd = '0;
        end else if (m_armed) begin
            chk("halted", 32'(halted), 32'(m_halted));
            f_el  = fetch_req && !m_halted;
            f_win = (f_el && dbg_req) ? m_last_dbg : f_el;
            d_win = dbg_req && !f_win;
            chk("fetch_gnt", 32'(fetch_gnt), 32'(f_win));
            chk("dbg_gnt",   32'(dbg_gnt),   32'(d_win));
            e_frv = 0; e_ferr = 0; e_frd = '0; e_drv = 0; e_derr = 0; e_drd = '0;
            if (f_win || d_win) begin
                a  = f_win ? fetch_addr : dbg_addr;
                wr = d_win && dbg_we;
                ok = addr_ok(a) && (!wr || m_halted);
                if (ok) begin
                    xa = a;
                    xd = wr ? dbg_wdata : 32'h0;
                end
                if (f_win) begin
                    e_frv = 1; e_ferr = !ok; e_frd = ok ? m_read(a) : 32'h0;
                end else begin
                    e_drv = 1; e_derr = !ok; e_drd = (ok && !wr) ? m_read(a) : 32'h0;
                end
                if (ok && wr) m_mem[a] = dbg_wdata;
                m_last_dbg = d_win;
            end
            chk("mem_address",    mem_address,         xa);
            chk("mem_read_write", 32'(mem_read_write), 32'(ok && wr));
            if (!(ok && !wr)) chk("mem_data_in", mem_data_in, xd);
            if (dbg_halt)        m_halted = 1;
            else if (dbg_resume) m_halted = 0;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fetch_req = 0; dbg_req = 0; dbg_we = 0; dbg_halt = 0; dbg_resume = 0;
    endtask

    initial begin
        bit          gseq [4];
        logic [31:0] t4_addr [4];
        bit          t4_err [4];
        gseq = '{1'b1, 1'b0, 1'b1, 1'b0};
        t4_addr = '{32'h0100_0002, 32'h00FF_FFFC, 32'h0110_0000, 32'h010F_FFFC};
        t4_err  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 64; i++) bmem[i] = pattern(BASE + 32'(i * 4));
        bmem[2] = 32'h00A0_0093;
        m_mem[32'h0100_0008] = 32'h00A0_0093;

        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);

        // 1: single fetch
        fetch_req = 1; fetch_addr = 32'h0100_0008;
        #1 chk("t1_fetch_gnt", 32'(fetch_gnt), 32'd1);
        tick(); idle();
        #1;
        chk("t1_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("t1_rdata", fetch_rdata, 32'h00A0_0093);
        chk("t1_err", 32'(fetch_err), 32'd0);

        // 2: collisions after reset alternate F,D,F,D
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1; fetch_addr = 32'h0100_000C;
            dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0100_0010;
            #1;
            chk("t2_fetch_gnt", 32'(fetch_gnt), 32'(gseq[i]));
            chk("t2_dbg_gnt", 32'(dbg_gnt), 32'(!gseq[i]));
            if (i > 0) begin
                chk("t2_fetch_rvalid", 32'(fetch_rvalid), 32'(gseq[i-1]));
                chk("t2_dbg_rvalid", 32'(dbg_rvalid), 32'(!gseq[i-1]));
            end
            tick();
        end
        idle();
        #1;
        chk("t2_last_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("t2_last_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        tick();

        // 3: write refused in RUN, accepted once halted, then read back
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h0100_0004; dbg_wdata = 32'hDEAD_BEEF;
        #1 chk("t3_run_rw", 32'(mem_read_write), 32'd0);
        tick(); idle();
        #1;
        chk("t3_run_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("t3_run_err", 32'(dbg_err), 32'd1);
        dbg_halt = 1;
        tick(); idle();
        #1 chk("t3_halted", 32'(halted), 32'd1);
        dbg_req = 1; dbg_we = 1;
        #1;
        chk("t3_wr_rw", 32'(mem_read_write), 32'd1);
        chk("t3_wr_addr", mem_address, 32'h0100_0004);
        tick(); idle();
        #1;
        chk("t3_ack_err", 32'(dbg_err), 32'd0);
        chk("t3_ack_rdata", dbg_rdata, 32'd0);
        chk("t3_rw_drop", 32'(mem_read_write), 32'd0);
        dbg_req = 1; dbg_we = 0;
        tick(); idle();
        #1 chk("t3_readback", dbg_rdata, 32'hDEAD_BEEF);

        // 5: fetch held off while halted; halt wins over resume
        fetch_req = 1; fetch_addr = 32'h0100_000C;
        #1 chk("t5_halted_gnt", 32'(fetch_gnt), 32'd0);
        tick();
        dbg_halt = 1; dbg_resume = 1;
        #1 chk("t5_both_gnt", 32'(fetch_gnt), 32'd0);
        tick();
        dbg_halt = 0; dbg_resume = 0;
        #1;
        chk("t5_still_halted", 32'(halted), 32'd1);
        chk("t5_still_no_gnt", 32'(fetch_gnt), 32'd0);
        dbg_resume = 1;
        tick();
        dbg_resume = 0;
        #1;
        chk("t5_resumed", 32'(halted), 32'd0);
        chk("t5_resume_gnt", 32'(fetch_gnt), 32'd1);
        tick(); idle(); tick();

        // 4: misaligned / below base / one past end, plus the last legal word
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1; fetch_addr = t4_addr[i];
            #1;
            chk("t4_mem_addr", mem_address, t4_err[i] ? BASE : t4_addr[i]);
            chk("t4_mem_rw", 32'(mem_read_write), 32'd0);
            tick(); idle();
            #1;
            chk("t4_rvalid", 32'(fetch_rvalid), 32'd1);
            chk("t4_err", 32'(fetch_err), 32'(t4_err[i]));
            chk("t4_rdata", fetch_rdata, t4_err[i] ? 32'h0 : 32'hA4AA_FFFC);
            tick();
        end

        // 6: reset right after a grant drops the response and clears halt
        fetch_req = 1; fetch_addr = 32'h0100_0008; dbg_halt = 1;
        #1 chk("t6_gnt", 32'(fetch_gnt), 32'd1);
        tick(); idle();
        reset = 1;
        #1 chk("t6_pending_rvalid", 32'(fetch_rvalid), 32'd1);
        tick();
        reset = 0;
        fetch_req = 1; fetch_addr = 32'h0100_0008;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0100_0010;
        #1;
        chk("t6_rvalid_dropped", 32'(fetch_rvalid), 32'd0);
        chk("t6_halted_clr", 32'(halted), 32'd0);
        chk("t6_fetch_first", 32'(fetch_gnt), 32'd1);
        chk("t6_dbg_wait", 32'(dbg_gnt), 32'd0);
        tick();
        #1 chk("t6_dbg_next", 32'(dbg_gnt), 32'd1);
        tick(); idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
